digit_scan_mux: RTL and testbench
=================================

DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles per digit slot; legal range GUARD+2 .. 2^24.
REQ-002 Parameter GUARD, default 2: anode-off cycles at the start of each slot (anti-ghost); legal range 0 .. CLK_DIV-2.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 value  input  16  four hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost.
REQ-006 load  input  1  when high at a clock edge, value, dp_in and blank_lz are captured into shadow registers.
REQ-007 dp_in  input  4  decimal point request per digit; bit i = digit i.
REQ-008 blank_lz  input  1  leading-zero suppression enable.
REQ-009 digit  output  4  registered nibble for the shared seven-segment decoder input.
REQ-010 an_n  output  4  registered active-low anode enables; at most one bit low.
REQ-011 dp_n  output  1  registered active-low decimal point for the active digit.
REQ-012 scan_tick  output  1  registered one-cycle pulse marking each slot advance.

Function
REQ-013 Prescaler SHALL count 0 .. CLK_DIV-1 every cycle and wrap to 0; "tick" = prescaler at CLK_DIV-1.
REQ-014 On the edge where tick is true, slot index idx SHALL advance 0->1->2->3->0 (mod 4).
REQ-015 On that same edge, guard counter SHALL load GUARD; otherwise it SHALL decrement while nonzero and hold at 0.
REQ-016 scan_tick SHALL be high for exactly the one cycle following the edge on which idx advanced.
REQ-017 Outputs SHALL be registered from the pre-edge values of idx, guard counter and shadow registers (one-cycle latency).
REQ-018 digit SHALL equal shadow nibble[idx] at all times after reset, including during guard and blanking.
REQ-019 While guard counter is nonzero, an_n SHALL be 4'b1111 and dp_n SHALL be 1.
REQ-020 Digit idx is "blanked" when shadow blank_lz=1, idx!=0, and shadow nibbles idx..3 are all zero; a blanked digit SHALL drive an_n=4'b1111 and dp_n=1 for its whole slot.
REQ-021 Digit 0 SHALL never be blanked.
REQ-022 Otherwise an_n SHALL be all ones except bit idx = 0, and dp_n SHALL be ~shadow dp[idx].
REQ-023 Each slot lasts CLK_DIV cycles: GUARD cycles dark, then CLK_DIV-GUARD cycles lit (unless blanked).
REQ-024 A load SHALL update the shadow registers on its edge; the outputs SHALL reflect the new data from the following edge onward, without restarting prescaler or idx.
REQ-025 A load coincident with a tick SHALL take effect together with the idx advance; the new slot SHALL display new data.
REQ-026 Back-to-back loads SHALL each overwrite the shadow registers; the last one wins.

Reset
REQ-027 While rst_n=0, without waiting for a clock edge: prescaler=0, idx=0, guard=0, shadow value=0, shadow dp=0, shadow blank_lz=0, digit=4'h0, an_n=4'b1111, dp_n=1, scan_tick=0.
REQ-028 An assertion of rst_n mid-slot or mid-guard SHALL abort the scan immediately; after release the scan SHALL restart from idx 0 with prescaler 0, and the first edge SHALL drive an_n=4'b1110, digit=4'h0.

Verification (CLK_DIV=8, GUARD=2)
REQ-029 Release rst_n, no load -> one edge later an_n=1110, digit=0, dp_n=1; scan_tick first high in the cycle after the 8th edge.
REQ-030 load value=16'h12AF, dp_in=4'b0100, blank_lz=0 -> slots show F/1110, A/1101, 2/1011 with dp_n=0, 1/0111; each slot 2 cycles an_n=1111 then 6 cycles lit; repeats every 32 cycles.
REQ-031 load 16'h0050, blank_lz=1 -> slots 3 and 2 an_n=1111 throughout; slot 1 shows 5; slot 0 shows 0; load 16'h0000 -> only slot 0 lit, showing 0.
REQ-032 load 16'h0007 on the tick edge entering slot 1, then 16'h0009 one cycle later -> slot 1 digit output shows 0 throughout; slot 0 shows 9.
REQ-033 Pull rst_n low between edges during a lit slot -> an_n=1111, dp_n=1, scan_tick=0 immediately; release -> scan resumes at slot 0 per REQ-028.

Source files
------------

// File: rtl/digit_scan_mux_if.sv
// Host-side bundle for the four-digit scan multiplexer: display data in, drive signals out.
interface digit_scan_mux_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        scan_tick;

    // Host drives data and load strobe, observes the display drive.
    modport master (
        output value, load, dp_in, blank_lz,
        input  digit, an_n, dp_n, scan_tick
    );

    // Scanner consumes data and load strobe, produces the display drive.
    modport slave (
        input  value, load, dp_in, blank_lz,
        output digit, an_n, dp_n, scan_tick
    );
endinterface

// File: rtl/digit_scan_mux.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Each digit slot lasts CLK_DIV cycles: GUARD dark cycles (anti-ghost), then lit.
// Optional leading-zero blanking; digit 0 is always shown.
// Legal ranges: GUARD+2 <= CLK_DIV <= 2**24, 0 <= GUARD <= CLK_DIV-2.
module digit_scan_mux #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned GUARD   = 2
) (
    input logic             clk,
    input logic             rst_n,
    digit_scan_mux_if.slave bus
);

    // Prescaler and guard counter share one width; GUARD < CLK_DIV always fits.
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LD = CW'(GUARD);

    // Scan state
    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q,   idx_d;
    logic [CW-1:0] guard_q, guard_d;

    // Shadow copies of the host data
    logic [15:0]   val_q,   val_d;
    logic [3:0]    dp_q,    dp_d;
    logic          blz_q,   blz_d;

    // Registered display drive
    logic [3:0]    digit_q, digit_d;
    logic [3:0]    an_q,    an_d;
    logic          dpn_q,   dpn_d;
    logic          stick_q, stick_d;

    // Combinational helpers
    logic          tick;
    logic [3:0]    cur_nib;
    logic          zero_from1, zero_from2, zero_from3;
    logic          blanked;

    // State and output registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            guard_q <= '0;
            val_q   <= 16'h0000;
            dp_q    <= 4'h0;
            blz_q   <= 1'b0;
            digit_q <= 4'h0;
            an_q    <= 4'b1111;
            dpn_q   <= 1'b1;
            stick_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            guard_q <= guard_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            blz_q   <= blz_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            dpn_q   <= dpn_d;
            stick_q <= stick_d;
        end
    end

    // Next scan state, shadow capture and display drive from pre-edge values.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        guard_d = guard_q;
        val_d   = val_q;
        dp_d    = dp_q;
        blz_d   = blz_q;
        digit_d = 4'h0;
        an_d    = 4'b1111;
        dpn_d   = 1'b1;
        stick_d = 1'b0;

        tick = (presc_q == DIV_LAST);

        // Slot timing: wrap prescaler, advance slot, rearm the dark guard window.
        if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
            guard_d = GUARD_LD;
        end else begin
            presc_d = presc_q + CW'(1);
            if (guard_q != '0) begin
                guard_d = guard_q - CW'(1);
            end
        end

        // Host load; scan timing is untouched so the display never restarts.
        if (bus.load) begin
            val_d = bus.value;
            dp_d  = bus.dp_in;
            blz_d = bus.blank_lz;
        end

        // A digit is a leading zero when it and every digit above it are zero.
        zero_from3 = (val_q[15:12] == 4'h0);
        zero_from2 = zero_from3 && (val_q[11:8] == 4'h0);
        zero_from1 = zero_from2 && (val_q[7:4] == 4'h0);
        case (idx_q)
            2'd1:    blanked = blz_q && zero_from1;
            2'd2:    blanked = blz_q && zero_from2;
            2'd3:    blanked = blz_q && zero_from3;
            default: blanked = 1'b0;
        endcase

        // Nibble is always presented, even while the anode is dark.
        cur_nib = 4'(val_q >> {idx_q, 2'b00});
        digit_d = cur_nib;

        if ((guard_q == '0) && !blanked) begin
            an_d  = ~(4'b0001 << idx_q);
            dpn_d = ~dp_q[idx_q];
        end

        stick_d = tick;
    end

    assign bus.digit     = digit_q;
    assign bus.an_n      = an_q;
    assign bus.dp_n      = dpn_q;
    assign bus.scan_tick = stick_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with CLK_DIV=8, GUARD=2.
module tb_digit_scan_mux;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   edge_n;

    digit_scan_mux_if bus ();

    digit_scan_mux #(
        .CLK_DIV (8),
        .GUARD   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it when it differs.
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) step();
    endtask

    // Check one full 8-cycle slot: 2 dark cycles, 6 lit, scan_tick on the last.
    task automatic check_slot(input logic [1:0] slot, input logic [3:0] dig,
                              input logic [3:0] an_lit, input logic dp_lit);
        for (int p = 0; p < 8; p++) begin
            step();
            bus.load = 1'b0;
            check_eq($sformatf("slot%0d p%0d digit", slot, p), 16'(bus.digit), 16'(dig));
            check_eq($sformatf("slot%0d p%0d an_n", slot, p), 16'(bus.an_n),
                     (p < 2) ? 16'hF : 16'(an_lit));
            check_eq($sformatf("slot%0d p%0d dp_n", slot, p), 16'(bus.dp_n),
                     (p < 2) ? 16'h1 : 16'(dp_lit));
            check_eq($sformatf("slot%0d p%0d scan_tick", slot, p), 16'(bus.scan_tick),
                     (p == 7) ? 16'h1 : 16'h0);
        end
    endtask

    task automatic load_data(input logic [15:0] v, input logic [3:0] dp, input logic blz);
        bus.value    = v;
        bus.dp_in    = dp;
        bus.blank_lz = blz;
        bus.load     = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        edge_n = 0;
        rst_n        = 1'b1;
        bus.value    = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.blank_lz = 1'b0;
        bus.load     = 1'b0;

        // Reset takes effect before any clock edge.
        #2 rst_n = 1'b0;
        #2;
        check_eq("rst an_n", 16'(bus.an_n), 16'hF);
        check_eq("rst digit", 16'(bus.digit), 16'h0);
        check_eq("rst dp_n", 16'(bus.dp_n), 16'h1);
        check_eq("rst scan_tick", 16'(bus.scan_tick), 16'h0);

        // Release between edges; first slot after reset has no guard.
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        edge_n = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            check_eq("boot an_n", 16'(bus.an_n), 16'hE);
            check_eq("boot digit", 16'(bus.digit), 16'h0);
            check_eq("boot dp_n", 16'(bus.dp_n), 16'h1);
            check_eq("boot scan_tick", 16'(bus.scan_tick), (e == 8) ? 16'h1 : 16'h0);
        end
        step();
        check_eq("slot1 guard an_n", 16'(bus.an_n), 16'hF);
        check_eq("slot1 scan_tick low", 16'(bus.scan_tick), 16'h0);

        // Mid-slot load of 12AF with dp on digit 2; scan timing must not restart.
        load_data(16'h12AF, 4'b0100, 1'b0);
        step();
        bus.load = 1'b0;
        run_to(16);
        check_slot(2'd2, 4'h2, 4'b1011, 1'b0);
        check_slot(2'd3, 4'h1, 4'b0111, 1'b1);
        check_slot(2'd0, 4'hF, 4'b1110, 1'b1);
        check_slot(2'd1, 4'hA, 4'b1101, 1'b1);

        // Leading-zero blanking of 0050: digits 3 and 2 dark.
        load_data(16'h0050, 4'h0, 1'b1);
        step();
        bus.load = 1'b0;
        run_to(56);
        check_slot(2'd3, 4'h0, 4'b1111, 1'b1);
        check_slot(2'd0, 4'h0, 4'b1110, 1'b1);
        check_slot(2'd1, 4'h5, 4'b1101, 1'b1);
        check_slot(2'd2, 4'h0, 4'b1111, 1'b1);

        // All zero with blanking: only digit 0 lit.
        load_data(16'h0000, 4'h0, 1'b1);
        step();
        bus.load = 1'b0;
        run_to(96);
        check_slot(2'd0, 4'h0, 4'b1110, 1'b1);
        check_slot(2'd1, 4'h0, 4'b1111, 1'b1);
        check_slot(2'd2, 4'h0, 4'b1111, 1'b1);
        check_slot(2'd3, 4'h0, 4'b1111, 1'b1);

        // Load on the tick edge into slot 1, then overwrite the next cycle.
        run_to(135);
        load_data(16'h0007, 4'h0, 1'b0);
        step();
        check_eq("tick-edge scan_tick", 16'(bus.scan_tick), 16'h1);
        load_data(16'h0009, 4'h0, 1'b0);
        check_slot(2'd1, 4'h0, 4'b1101, 1'b1);
        check_slot(2'd2, 4'h0, 4'b1011, 1'b1);
        check_slot(2'd3, 4'h0, 4'b0111, 1'b1);
        check_slot(2'd0, 4'h9, 4'b1110, 1'b1);

        // Reset asserted mid lit slot with dp active.
        load_data(16'h4321, 4'b0010, 1'b0);
        step();
        bus.load = 1'b0;
        run_to(173);
        check_eq("prelit an_n", 16'(bus.an_n), 16'hD);
        check_eq("prelit digit", 16'(bus.digit), 16'h2);
        check_eq("prelit dp_n", 16'(bus.dp_n), 16'h0);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midslot rst an_n", 16'(bus.an_n), 16'hF);
        check_eq("midslot rst dp_n", 16'(bus.dp_n), 16'h1);
        check_eq("midslot rst digit", 16'(bus.digit), 16'h0);
        check_eq("midslot rst scan_tick", 16'(bus.scan_tick), 16'h0);
        step();
        check_eq("held rst an_n", 16'(bus.an_n), 16'hF);
        @(negedge clk) rst_n = 1'b1;
        edge_n = 0;
        step();
        check_eq("restart an_n", 16'(bus.an_n), 16'hE);
        check_eq("restart digit", 16'(bus.digit), 16'h0);
        check_eq("restart dp_n", 16'(bus.dp_n), 16'h1);

        // Reset asserted while scan_tick is high clears it at once.
        run_to(7);
        check_eq("pre-tick scan_tick", 16'(bus.scan_tick), 16'h0);
        step();
        check_eq("restart scan_tick", 16'(bus.scan_tick), 16'h1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("tick rst scan_tick", 16'(bus.scan_tick), 16'h0);
        check_eq("tick rst an_n", 16'(bus.an_n), 16'hF);
        @(negedge clk) rst_n = 1'b1;
        edge_n = 0;
        step();
        check_eq("restart2 an_n", 16'(bus.an_n), 16'hE);
        check_eq("restart2 scan_tick", 16'(bus.scan_tick), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
